// File: rtl/mux_4_1.sv
`default_nettype none
// ============================================================================
// Module      : mux_4_1
// Description : Parameterised 4-to-1 word multiplexer with a registered
//               output. The word picked by `sel` is captured on every rising
//               edge of `clk`, giving downstream logic a glitch-free,
//               clock-aligned result one cycle after the inputs are sampled.
//
// Parameters  : ANCHO  - data width in bits (>= 1) for a/b/c/d/out
//
// Ports       : clk    in   1      system clock, rising-edge active
//               rst_n  in   1      synchronous active-low reset
//               a      in   ANCHO  data word 0 (sel = 2'b00)
//               b      in   ANCHO  data word 1 (sel = 2'b01)
//               c      in   ANCHO  data word 2 (sel = 2'b10)
//               d      in   ANCHO  data word 3 (sel = 2'b11)
//               sel    in   2      select code
//               out    out  ANCHO  registered selected word
//
// Revision    : 1.0  initial release
// ============================================================================
module mux_4_1 #(
    parameter int ANCHO = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    input  logic [ANCHO-1:0] c,
    input  logic [ANCHO-1:0] d,
    input  logic [1:0]       sel,
    output logic [ANCHO-1:0] out
);

    localparam logic [1:0] c_SEL_A = 2'b00;
    localparam logic [1:0] c_SEL_B = 2'b01;
    localparam logic [1:0] c_SEL_C = 2'b10;
    localparam logic [1:0] c_SEL_D = 2'b11;

    logic [ANCHO-1:0] w_out_d;
    logic [ANCHO-1:0] r_out_q;

    // The four select codes cover the whole 2-bit space, so the leading
    // default only exists to make the block obviously latch-free; it is
    // never the final value for a known `sel`.
    always_comb begin
        w_out_d = '0;
        case (sel)
            c_SEL_A: w_out_d = a;
            c_SEL_B: w_out_d = b;
            c_SEL_C: w_out_d = c;
            c_SEL_D: w_out_d = d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_q <= '0;
        end else begin
            r_out_q <= w_out_d;
        end
    end

    assign out = r_out_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_4_1.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_4_1
// Description : Self-checking bench for mux_4_1. A 4-bit instance exercises
//               reset, select walking, isolation of unselected inputs, a
//               per-channel data sweep and mid-stream reset; an 8-bit
//               instance covers width scaling. Expected words are queued
//               when stimulus is applied and compared after the capturing
//               edge.
//
// Revision    : 1.0  initial release
// ============================================================================
module tb_mux_4_1;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit instance
    logic       rst_n;
    logic [3:0] a, b, c, d;
    logic [1:0] sel;
    logic [3:0] out;

    // 8-bit instance
    logic       rst8_n;
    logic [7:0] a8, b8, c8, d8;
    logic [1:0] sel8;
    logic [7:0] out8;

    int checks   = 0;
    int failures = 0;

    logic [3:0] sb4[$];
    logic [7:0] sb8[$];

    mux_4_1 #(.ANCHO(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .sel   (sel),
        .out   (out)
    );

    mux_4_1 #(.ANCHO(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst8_n),
        .a     (a8),
        .b     (b8),
        .c     (c8),
        .d     (d8),
        .sel   (sel8),
        .out   (out8)
    );

    // Drive one cycle of stimulus on the 4-bit instance, queue the word it
    // must produce, then check it one edge later.
    task automatic step4(input logic r, input logic [1:0] s,
                         input logic [3:0] ia, input logic [3:0] ib,
                         input logic [3:0] ic, input logic [3:0] id,
                         input logic [3:0] exp_w, input string tag);
        logic [3:0] e;
        rst_n = r;
        sel   = s;
        a     = ia;
        b     = ib;
        c     = ic;
        d     = id;
        sb4.push_back(exp_w);
        @(posedge clk);
        #1;
        e = sb4.pop_front();
        checks++;
        assert (out === e) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, out, e);
            $error("check %s: observed=%h expected=%h", tag, out, e);
        end
    endtask

    task automatic step8(input logic r, input logic [1:0] s,
                         input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] ic, input logic [7:0] id,
                         input logic [7:0] exp_w, input string tag);
        logic [7:0] e;
        rst8_n = r;
        sel8   = s;
        a8     = ia;
        b8     = ib;
        c8     = ic;
        d8     = id;
        sb8.push_back(exp_w);
        @(posedge clk);
        #1;
        e = sb8.pop_front();
        checks++;
        assert (out8 === e) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, out8, e);
            $error("check %s: observed=%h expected=%h", tag, out8, e);
        end
    endtask

    initial begin
        logic [3:0] v;
        logic [3:0] nv;

        rst_n  = 1'b0;
        sel    = 2'b00;
        a = 4'h0; b = 4'h0; c = 4'h0; d = 4'h0;
        rst8_n = 1'b0;
        sel8   = 2'b00;
        a8 = 8'h00; b8 = 8'h00; c8 = 8'h00; d8 = 8'h00;

        // Reset held for two edges with every input high.
        step4(1'b0, 2'b10, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, "reset_edge0");
        step4(1'b0, 2'b10, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, "reset_edge1");

        // Walk each select with one-hot data words.
        step4(1'b1, 2'b00, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, "walk_sel00");
        step4(1'b1, 2'b01, 4'h1, 4'h2, 4'h4, 4'h8, 4'h2, "walk_sel01");
        step4(1'b1, 2'b10, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, "walk_sel10");
        step4(1'b1, 2'b11, 4'h1, 4'h2, 4'h4, 4'h8, 4'h8, "walk_sel11");

        // Unselected inputs toggle freely; out must stay at b.
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            step4(1'b1, 2'b01, v, 4'h5, ~v, v ^ 4'h6, 4'h5, "isolation");
        end

        // Per-channel sweep; the other inputs carry the complement so a
        // wrong pick cannot alias onto the expected word.
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 16; i++) begin
                v  = 4'(i);
                nv = ~v;
                case (s)
                    0: step4(1'b1, 2'b00, v,  nv, nv, nv, v, "sweep_a");
                    1: step4(1'b1, 2'b01, nv, v,  nv, nv, v, "sweep_b");
                    2: step4(1'b1, 2'b10, nv, nv, v,  nv, v, "sweep_c");
                    default: step4(1'b1, 2'b11, nv, nv, nv, v, v, "sweep_d");
                endcase
            end
        end

        // Reset pulse in the middle of a stream.
        step4(1'b1, 2'b11, 4'h3, 4'h3, 4'h3, 4'hA, 4'hA, "midrst_pre");
        step4(1'b0, 2'b11, 4'h3, 4'h3, 4'h3, 4'hA, 4'h0, "midrst_low");
        step4(1'b1, 2'b11, 4'h3, 4'h3, 4'h3, 4'hA, 4'hA, "midrst_post");

        // Width scaling on the 8-bit instance.
        step8(1'b0, 2'b00, 8'hA5, 8'h11, 8'h22, 8'h5A, 8'h00, "w8_reset");
        step8(1'b1, 2'b00, 8'hA5, 8'h11, 8'h22, 8'h5A, 8'hA5, "w8_sel00");
        step8(1'b1, 2'b11, 8'hA5, 8'h11, 8'h22, 8'h5A, 8'h5A, "w8_sel11");
        step8(1'b0, 2'b11, 8'hA5, 8'h11, 8'h22, 8'h5A, 8'h00, "w8_reset2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
